// File: rtl/sb_pkg.sv
// Shared switch-box constants: per-track switch bit positions, topology and config-load states.
// Imported by switch_box_chain and sb_track_switch.
package sb_pkg;

    localparam int SB_NE = 0;
    localparam int SB_NS = 1;
    localparam int SB_NW = 2;
    localparam int SB_ES = 3;
    localparam int SB_EW = 4;
    localparam int SB_SW = 5;
    localparam int SB_SWITCHES_PER_TRACK = 6;

    typedef enum logic [0:0] {
        SB_TOPO_DISJOINT = 1'b0,
        SB_TOPO_WILTON   = 1'b1
    } sb_topo_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_FULL    = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/sb_track_switch.sv
// Six bidirectional pass switches joining the four sides of one track element.
// Purely combinational; a set bit closes the corresponding switch.
module sb_track_switch
    import sb_pkg::*;
(
    input  logic [SB_SWITCHES_PER_TRACK-1:0] sw,
    inout  wire                              n,
    inout  wire                              e,
    inout  wire                              s,
    inout  wire                              w
);

    // Each switch is a pair of opposing tri-state drivers.
    assign n = sw[SB_NE] ? e : 1'bz;
    assign e = sw[SB_NE] ? n : 1'bz;
    assign n = sw[SB_NS] ? s : 1'bz;
    assign s = sw[SB_NS] ? n : 1'bz;
    assign n = sw[SB_NW] ? w : 1'bz;
    assign w = sw[SB_NW] ? n : 1'bz;
    assign e = sw[SB_ES] ? s : 1'bz;
    assign s = sw[SB_ES] ? e : 1'bz;
    assign e = sw[SB_EW] ? w : 1'bz;
    assign w = sw[SB_EW] ? e : 1'bz;
    assign s = sw[SB_SW] ? w : 1'bz;
    assign w = sw[SB_SW] ? s : 1'bz;

endmodule

// File: rtl/switch_box_chain.sv
// Switch box with a scan-loaded shadow config and commit-to-active; N_WORDS cycles of chain latency.
// Optional readback of the active image via cfg_capture when SB_CFG_READBACK_EN is defined.
module switch_box_chain
    import sb_pkg::*;
#(
    parameter int W           = 8,
    parameter int TOPOLOGY    = 0,
    parameter int CHAIN_WIDTH = 1,
    parameter int CONF_WIDTH  = SB_SWITCHES_PER_TRACK * W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic [CHAIN_WIDTH-1:0] cfg_in,
    output logic [CHAIN_WIDTH-1:0] cfg_out,
    input  logic                   cfg_commit,
`ifdef SB_CFG_READBACK_EN
    input  logic                   cfg_capture,
`endif
    output logic                   cfg_full,
    output logic                   cfg_err,
    output logic                   cfg_valid,
    inout  wire  [W-1:0]           north,
    inout  wire  [W-1:0]           east,
    inout  wire  [W-1:0]           south,
    inout  wire  [W-1:0]           west
);

    localparam int N_WORDS = CONF_WIDTH / CHAIN_WIDTH;
    localparam int CNT_W   = $clog2(N_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_WORDS);

    cfg_state_e            state, state_nxt;
    logic [CNT_W-1:0]      count, count_nxt;
    logic [CONF_WIDTH-1:0] shadow, shadow_nxt;
    logic [CONF_WIDTH-1:0] active;
    logic                  commit_ok, commit_bad, capture_ok, err_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        commit_ok  = cfg_commit && !cfg_en && (state == ST_FULL);
        commit_bad = cfg_commit && !commit_ok;
`ifdef SB_CFG_READBACK_EN
        capture_ok = cfg_capture && !cfg_en && !cfg_commit;
`else
        capture_ok = 1'b0;
`endif
        count_nxt  = count;
        shadow_nxt = shadow;
        if (cfg_en) begin
            shadow_nxt = {cfg_in, shadow[CONF_WIDTH-1:CHAIN_WIDTH]};
            if (count != CNT_MAX) count_nxt = count + 1'b1;
        end else if (commit_ok) begin
            count_nxt = '0;
        end else if (capture_ok) begin
            shadow_nxt = active;
            count_nxt  = '0;
        end
        // A rejected commit wins over the clear from a simultaneous shift.
        err_nxt = commit_bad ? 1'b1 : (cfg_en ? 1'b0 : cfg_err);
        if (count_nxt == '0)          state_nxt = ST_EMPTY;
        else if (count_nxt == CNT_MAX) state_nxt = ST_FULL;
        else                          state_nxt = ST_LOADING;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            shadow    <= '0;
            active    <= '0;
            cfg_err   <= 1'b0;
            cfg_valid <= 1'b0;
        end else begin
            count   <= count_nxt;
            shadow  <= shadow_nxt;
            cfg_err <= err_nxt;
            if (commit_ok) begin
                active    <= shadow;
                cfg_valid <= 1'b1;
            end
        end
    end

    assign cfg_out  = shadow[CHAIN_WIDTH-1:0];
    assign cfg_full = (state == ST_FULL);

    for (genvar i = 0; i < W; i++) begin : g_track
        localparam bit WILTON = (TOPOLOGY == int'(SB_TOPO_WILTON));
        localparam int EI = WILTON ? (i + 1) % W : i;
        localparam int WI = WILTON ? (i + W - 1) % W : i;
        sb_track_switch u_sw (
            .sw (active[SB_SWITCHES_PER_TRACK*i +: SB_SWITCHES_PER_TRACK]),
            .n  (north[i]),
            .e  (east[EI]),
            .s  (south[i]),
            .w  (west[WI])
        );
    end

endmodule

// File: tb/tb_switch_box_chain.sv
// Directed bench: two disjoint boxes daisy-chained plus one Wilton box on a shared enable/commit bus.
// Tracks are pulled low so an open track reads 0; readback is exercised when SB_CFG_READBACK_EN is defined.
module tb_switch_box_chain;

    localparam int W = 8;
    localparam logic [47:0] A_IMG  = 48'h1 << 12;                 // element 2 NE
    localparam logic [47:0] B_IMG  = (48'h1 << 0) | (48'h1 << 31); // element 0 NE, element 5 NS
    localparam logic [47:0] WI_IMG = (48'h1 << 42) | (48'h1 << 2); // element 7 NE, element 0 NW
    localparam logic [47:0] RB_IMG = 48'hA5A5_5A5A_C3C3;

    logic clk = 1'b0;
    logic rst, cfg_en, cfg_commit, a_in, w_in;
`ifdef SB_CFG_READBACK_EN
    logic cfg_capture;
`endif
    logic a_out, b_out, w_out;
    logic a_full, a_err, a_valid, b_full, b_err, b_valid, w_full, w_err, w_valid;
    logic [W-1:0] a_drv, b_drv, w_drv;
    wire  [W-1:0] a_n, a_e, a_s, a_w, b_n, b_e, b_s, b_w, w_n, w_e, w_s, w_w;
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < W; k++) begin : g_trk
        assign a_n[k] = a_drv[k] ? 1'b1 : 1'bz;
        assign b_n[k] = b_drv[k] ? 1'b1 : 1'bz;
        assign w_n[k] = w_drv[k] ? 1'b1 : 1'bz;
        pulldown (a_n[k]); pulldown (a_e[k]); pulldown (a_s[k]); pulldown (a_w[k]);
        pulldown (b_n[k]); pulldown (b_e[k]); pulldown (b_s[k]); pulldown (b_w[k]);
        pulldown (w_n[k]); pulldown (w_e[k]); pulldown (w_s[k]); pulldown (w_w[k]);
    end

    switch_box_chain #(.W(W), .TOPOLOGY(0), .CHAIN_WIDTH(1)) u_a (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_in(a_in), .cfg_out(a_out),
        .cfg_commit(cfg_commit),
`ifdef SB_CFG_READBACK_EN
        .cfg_capture(cfg_capture),
`endif
        .cfg_full(a_full), .cfg_err(a_err), .cfg_valid(a_valid),
        .north(a_n), .east(a_e), .south(a_s), .west(a_w)
    );

    switch_box_chain #(.W(W), .TOPOLOGY(0), .CHAIN_WIDTH(1)) u_b (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_in(a_out), .cfg_out(b_out),
        .cfg_commit(cfg_commit),
`ifdef SB_CFG_READBACK_EN
        .cfg_capture(cfg_capture),
`endif
        .cfg_full(b_full), .cfg_err(b_err), .cfg_valid(b_valid),
        .north(b_n), .east(b_e), .south(b_s), .west(b_w)
    );

    switch_box_chain #(.W(W), .TOPOLOGY(1), .CHAIN_WIDTH(1)) u_w (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_in(w_in), .cfg_out(w_out),
        .cfg_commit(cfg_commit),
`ifdef SB_CFG_READBACK_EN
        .cfg_capture(cfg_capture),
`endif
        .cfg_full(w_full), .cfg_err(w_err), .cfg_valid(w_valid),
        .north(w_n), .east(w_e), .south(w_s), .west(w_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Shift bits [first +: n] of the two images into box A's and box W's chain inputs, LSB first.
    task automatic load(input logic [47:0] img_a, input logic [47:0] img_w,
                        input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            cfg_en = 1'b1;
            a_in   = img_a[k];
            w_in   = img_w[k];
            tick();
        end
        cfg_en = 1'b0;
        a_in   = 1'b0;
        w_in   = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [47:0] rb;
        rst = 1'b1; cfg_en = 1'b0; cfg_commit = 1'b0; a_in = 1'b0; w_in = 1'b0;
        a_drv = '0; b_drv = '0; w_drv = '0;
`ifdef SB_CFG_READBACK_EN
        cfg_capture = 1'b0;
`endif
        do_reset();
        chk("reset_full",  a_full,  0);
        chk("reset_err",   a_err,   0);
        chk("reset_valid", a_valid, 0);
        chk("reset_out",   a_out,   0);

        // Load and commit a single NE closure on element 2.
        load(A_IMG, '0, 0, 47);
        chk("full_at_47", a_full, 0);
        load(A_IMG, '0, 47, 1);
        chk("full_at_48", a_full, 1);
        a_drv = 8'h04; #1;
        chk("precommit_open", a_e, 0);
        commit();
        chk("commit_valid", a_valid, 1);
        chk("commit_count_clr", a_full, 0);
        chk("commit_err", a_err, 0);
        chk("ne_east", a_e, 8'h04);
        chk("ne_south", a_s, 0);
        chk("ne_west", a_w, 0);
        a_drv = '0;
        do_reset();

        // Early commit after 10 shifts is rejected; err clears on the next shift.
        load(A_IMG, '0, 0, 10);
        commit();
        chk("early_err", a_err, 1);
        chk("early_valid", a_valid, 0);
        a_drv = 8'h04; #1;
        chk("early_open", a_e, 0);
        a_drv = '0;
        load(A_IMG, '0, 10, 1);
        chk("err_clear_on_shift", a_err, 0);
        do_reset();

        // Daisy chain: B's image first, then A's; W box loads in parallel.
        load(B_IMG, '0, 0, 47);
        chk("chain_out_47", a_out, 0);
        load(B_IMG, '0, 47, 1);
        chk("chain_out_48", a_out, 1);
        load(A_IMG, WI_IMG, 0, 48);
        chk("chain_full_a", a_full, 1);
        chk("chain_full_b", b_full, 1);
        commit();
        chk("chain_valid_b", b_valid, 1);
        a_drv = 8'h04; b_drv = 8'h21; w_drv = 8'h81; #1;
        chk("chain_a_east", a_e, 8'h04);
        chk("chain_a_south", a_s, 0);
        chk("chain_b_east", b_e, 8'h01);
        chk("chain_b_south", b_s, 8'h20);
        chk("wilton_east", w_e, 8'h01);
        chk("wilton_west", w_w, 8'h80);
        chk("wilton_south", w_s, 0);
        a_drv = '0; b_drv = '0; w_drv = '0;
        do_reset();

        // Shift and commit together while FULL: shift happens, commit rejected.
        load(A_IMG, '0, 0, 48);
        cfg_en = 1'b1; cfg_commit = 1'b1;
        tick();
        cfg_en = 1'b0; cfg_commit = 1'b0;
        chk("collide_err", a_err, 1);
        chk("collide_valid", a_valid, 0);
        chk("collide_full", a_full, 1);
        a_drv = 8'h04; #1;
        chk("collide_open", a_e, 0);
        a_drv = '0;

        // Commit a valid image, then reset in the middle of the next load.
        commit();
        chk("recommit_valid", a_valid, 1);
        load(A_IMG, '0, 0, 20);
        do_reset();
        chk("midload_full", a_full, 0);
        chk("midload_err", a_err, 0);
        chk("midload_valid", a_valid, 0);
        chk("midload_out", a_out, 0);
        a_drv = 8'h04; #1;
        chk("midload_open", a_e, 0);
        a_drv = '0;
        load(A_IMG, '0, 0, 47);
        chk("midload_cnt_47", a_full, 0);
        load(A_IMG, '0, 47, 1);
        chk("midload_cnt_48", a_full, 1);

`ifdef SB_CFG_READBACK_EN
        do_reset();
        load(RB_IMG, '0, 0, 48);
        commit();
        load('0, '0, 0, 5);
        cfg_capture = 1'b1;
        tick();
        cfg_capture = 1'b0;
        chk("capture_count", a_full, 0);
        rb = '0;
        for (int k = 0; k < 48; k++) begin
            rb[k] = a_out;
            load('0, '0, 0, 1);
        end
        chk("readback", rb, RB_IMG);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
